// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter / next-PC stage of the single-cycle CPU.
//
// Selects and registers the next PC from the jump/branch flags, drives the
// $ra link-write enable, runs the RUN/HALT state machine and keeps the panel
// performance counters.
//
// Ports:
//   in_clk, in_rst_n       clock, synchronous active-low reset
//   in_J/in_JW/in_JR       jump, jal, jump-register flags (jr sets J and JR)
//   in_BEQ/in_BNE/in_BGEZ  conditional branch flags
//   in_equal               ALU equal flag (rs == rt)
//   in_rs                  rs value: JR target, bit 31 is the bgez sign
//   in_imm16               branch word offset
//   in_target26            jump target field
//   in_halt, in_go         syscall-halt of current instruction, resume request
//   out_pc, out_pc_plus4   current PC and PC + 4 (jal link value)
//   out_link_we            register-file write enable for $ra
//   out_taken, out_halted  branch taken this cycle, FSM in HALT
//   out_cycles/out_jumps/out_branches/out_taken_cnt  performance counters
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_J,
  input  logic             in_JW,
  input  logic             in_JR,
  input  logic             in_BEQ,
  input  logic             in_BNE,
  input  logic             in_BGEZ,
  input  logic             in_equal,
  input  logic [31:0]      in_rs,
  input  logic [15:0]      in_imm16,
  input  logic [25:0]      in_target26,
  input  logic             in_halt,
  input  logic             in_go,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic             out_link_we,
  output logic             out_taken,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cycles,
  output logic [CNT_W-1:0] out_jumps,
  output logic [CNT_W-1:0] out_branches,
  output logic [CNT_W-1:0] out_taken_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] br_tgt, j_tgt;
  logic        taken;
  logic        running;
  logic        inc_cycles, inc_jumps, inc_branches, inc_taken;

  logic [CNT_W-1:0] cycles, jumps, branches, taken_cnt;

  // Target arithmetic; all sums wrap mod 2^32.
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{in_imm16[15]}}, in_imm16, 2'b00};
  assign j_tgt    = {pc_plus4[31:28], in_target26, 2'b00};
  assign taken    = (in_BEQ & in_equal) | (in_BNE & ~in_equal) | (in_BGEZ & ~in_rs[31]);
  assign running  = (state == RUN);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    out_link_we  = 1'b0;
    out_taken    = 1'b0;
    inc_cycles   = 1'b0;
    inc_jumps    = 1'b0;
    inc_branches = 1'b0;
    inc_taken    = 1'b0;

    case (state)
      RUN: begin
        out_taken  = taken;
        inc_cycles = 1'b1;
        if (in_halt) begin
          // Halt suppresses the instruction's jump/branch and its counting.
          state_next = HALT;
        end else begin
          out_link_we  = in_JW;
          inc_jumps    = in_J | in_JR | in_JW;
          inc_branches = in_BEQ | in_BNE | in_BGEZ;
          inc_taken    = taken;
          // jr asserts J as well, so JR must be tested first.
          if (in_JR)             pc_next = in_rs;
          else if (in_J | in_JW) pc_next = j_tgt;
          else if (taken)        pc_next = br_tgt;
          else                   pc_next = pc_plus4;
        end
      end
      HALT: begin
        if (in_go) begin
          state_next = RUN;
          pc_next    = pc_plus4;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      cycles    <= '0;
      jumps     <= '0;
      branches  <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (inc_cycles)   cycles    <= cycles + CNT_ONE;
      if (inc_jumps)    jumps     <= jumps + CNT_ONE;
      if (inc_branches) branches  <= branches + CNT_ONE;
      if (inc_taken)    taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

  assign out_pc        = pc;
  assign out_pc_plus4  = pc_plus4;
  assign out_halted    = ~running;
  assign out_cycles    = cycles;
  assign out_jumps     = jumps;
  assign out_branches  = branches;
  assign out_taken_cnt = taken_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. A second instance with CNT_W = 4
// shares the stimulus and is used for the counter-wrap case.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        j, jw, jr, beq, bne, bgez, equal, halt, go;
  logic [31:0] rs;
  logic [15:0] imm16;
  logic [25:0] target26;

  logic [31:0] pc, pc_plus4;
  logic        link_we, taken, halted;
  logic [31:0] cycles, jumps, branches, taken_cnt;

  logic [31:0] pc4_unused, pc4_plus4_unused;
  logic        link4_unused, taken4_unused, halted4_unused;
  logic [3:0]  cycles4, jumps4_unused, branches4_unused, taken_cnt4_unused;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_J(j), .in_JW(jw), .in_JR(jr),
    .in_BEQ(beq), .in_BNE(bne), .in_BGEZ(bgez), .in_equal(equal),
    .in_rs(rs), .in_imm16(imm16), .in_target26(target26),
    .in_halt(halt), .in_go(go),
    .out_pc(pc), .out_pc_plus4(pc_plus4), .out_link_we(link_we),
    .out_taken(taken), .out_halted(halted),
    .out_cycles(cycles), .out_jumps(jumps), .out_branches(branches),
    .out_taken_cnt(taken_cnt)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_dut4 (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_J(j), .in_JW(jw), .in_JR(jr),
    .in_BEQ(beq), .in_BNE(bne), .in_BGEZ(bgez), .in_equal(equal),
    .in_rs(rs), .in_imm16(imm16), .in_target26(target26),
    .in_halt(halt), .in_go(go),
    .out_pc(pc4_unused), .out_pc_plus4(pc4_plus4_unused),
    .out_link_we(link4_unused), .out_taken(taken4_unused),
    .out_halted(halted4_unused),
    .out_cycles(cycles4), .out_jumps(jumps4_unused),
    .out_branches(branches4_unused), .out_taken_cnt(taken_cnt4_unused)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    j = 0; jw = 0; jr = 0; beq = 0; bne = 0; bgez = 0; equal = 0;
    halt = 0; go = 0; rs = '0; imm16 = '0; target26 = '0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag, input int c, input int jm, input int b, input int t);
    check({tag, ".cycles"},    cycles,    c);
    check({tag, ".jumps"},     jumps,     jm);
    check({tag, ".branches"},  branches,  b);
    check({tag, ".taken_cnt"}, taken_cnt, t);
  endtask

  // Use a jr to place the PC at an arbitrary address.
  task automatic load_pc(input logic [31:0] addr);
    clear_flags();
    jr = 1; rs = addr;
    step();
    clear_flags();
  endtask

  initial begin
    clear_flags();
    rst_n = 0;
    step();
    step();
    rst_n = 1;

    // Reset state and sequential fetch.
    check("reset.pc", pc, 32'h0);
    check("reset.halted", {31'b0, halted}, 32'h0);
    check_counters("reset", 0, 0, 0, 0);
    step(); check("seq.pc1", pc, 32'h4);
    step(); check("seq.pc2", pc, 32'h8);
    step(); check("seq.pc3", pc, 32'hC);
    check_counters("seq", 3, 0, 0, 0);

    // beq taken, backward offset.
    load_pc(32'h10);                          // cycles 4, jumps 1
    check("beq.setup_pc", pc, 32'h10);
    beq = 1; equal = 1; imm16 = 16'hFFFE;
    #1 check("beq.taken", {31'b0, taken}, 32'h1);
    step(); clear_flags();
    check("beq.pc", pc, 32'h0C);
    check_counters("beq", 5, 1, 1, 1);

    // bne not taken.
    load_pc(32'h10);                          // cycles 6, jumps 2
    bne = 1; equal = 1; imm16 = 16'h0010;
    #1 check("bne.taken", {31'b0, taken}, 32'h0);
    step(); clear_flags();
    check("bne.pc", pc, 32'h14);
    check_counters("bne", 7, 2, 2, 1);

    // bgez on non-negative rs: taken, forward offset 3 words from 0x14.
    bgez = 1; rs = 32'h0000_0005; imm16 = 16'h0003;
    step(); clear_flags();
    check("bgez_pos.pc", pc, 32'h24);
    // bgez on negative rs: not taken.
    bgez = 1; rs = 32'h8000_0000; imm16 = 16'h0003;
    #1 check("bgez_neg.taken", {31'b0, taken}, 32'h0);
    step(); clear_flags();
    check("bgez_neg.pc", pc, 32'h28);
    check_counters("bgez", 9, 2, 4, 2);

    // jal: link write and region-preserving target.
    load_pc(32'h3000_0000);                   // cycles 10, jumps 3
    jw = 1; target26 = 26'h0000040;
    #1 check("jal.link_we", {31'b0, link_we}, 32'h1);
    check("jal.pc_plus4", pc_plus4, 32'h3000_0004);
    step(); clear_flags();
    check("jal.pc", pc, 32'h3000_0100);
    check("jal.jumps", jumps, 32'd4);

    // jr with J also set: JR wins.
    j = 1; jr = 1; rs = 32'h200; target26 = 26'h3FFFFFF;
    step(); clear_flags();
    check("jr_j.pc", pc, 32'h200);
    check_counters("jr_j", 12, 5, 4, 2);

    // Halt beats a jump on the same cycle.
    load_pc(32'h20);                          // cycles 13, jumps 6
    halt = 1; j = 1; jw = 1; target26 = 26'h0000100;
    #1 check("halt.link_we", {31'b0, link_we}, 32'h0);
    step();
    check("halt.pc", pc, 32'h20);
    check("halt.halted", {31'b0, halted}, 32'h1);
    check_counters("halt", 14, 6, 4, 2);
    // Stay halted with noisy flags; halt input ignored, nothing counts.
    beq = 1; equal = 1;
    for (int i = 0; i < 5; i++) step();
    check("halted.pc", pc, 32'h20);
    check("halted.taken", {31'b0, taken}, 32'h0);
    check("halted.link_we", {31'b0, link_we}, 32'h0);
    check_counters("halted", 14, 6, 4, 2);
    // Resume.
    clear_flags(); go = 1;
    step(); go = 0;
    check("go.pc", pc, 32'h24);
    check("go.halted", {31'b0, halted}, 32'h0);
    check("go.cycles", cycles, 32'd14);
    step();
    check("run_after_go.pc", pc, 32'h28);
    check("run_after_go.cycles", cycles, 32'd15);

    // Reset while halted, with go and halt both high.
    halt = 1;
    step();
    check("halt2.halted", {31'b0, halted}, 32'h1);
    go = 1; rst_n = 0;
    step();
    rst_n = 1; clear_flags();
    check("rst_in_halt.pc", pc, 32'h0);
    check("rst_in_halt.halted", {31'b0, halted}, 32'h0);
    check_counters("rst_in_halt", 0, 0, 0, 0);

    // Counter wrap on the CNT_W = 4 instance.
    for (int i = 0; i < 15; i++) step();
    check("wrap.cycles4_15", {28'b0, cycles4}, 32'd15);
    step();
    check("wrap.cycles4_16", {28'b0, cycles4}, 32'd0);
    check("wrap.cycles32_16", cycles, 32'd16);
    check("wrap.pc", pc, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the bench is directed and short; anything past this is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and next-PC stage of the single-cycle CPU.
- Consumes the jump/branch control flags from the jump-control decoder, plus the ALU equal flag and the rs operand.
- Selects and registers the next PC, drives the link-write enable, and implements the halt/resume state machine.
- Maintains the performance counters (cycles, jumps, branches, taken branches) shown on the panel.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- in_clk  input  1  clock; all state updates on its rising edge.
- in_rst_n  input  1  reset; synchronous, active-low.
- in_J  input  1  unconditional jump flag; also asserted together with in_JR for jr.
- in_JW  input  1  jal: jump with link write.
- in_JR  input  1  jump-register.
- in_BEQ  input  1  beq flag.
- in_BNE  input  1  bne flag.
- in_BGEZ  input  1  bgez flag.
- in_equal  input  1  ALU equal flag (rs == rt).
- in_rs  input  32  rs register value; JR target, and bit 31 for bgez.
- in_imm16  input  16  branch offset in words.
- in_target26  input  26  jump target field.
- in_halt  input  1  syscall-halt condition of the current instruction.
- in_go  input  1  resume request, level-sampled.
- out_pc  output  32  current PC (instruction ROM address).
- out_pc_plus4  output  32  out_pc + 4; link value for jal.
- out_link_we  output  1  register-file write enable for $ra.
- out_taken  output  1  a branch is taken this cycle.
- out_halted  output  1  state machine is in HALT.
- out_cycles  output  CNT_W  count of RUN cycles.
- out_jumps  output  CNT_W  count of retired jumps.
- out_branches  output  CNT_W  count of retired conditional branches.
- out_taken_cnt  output  CNT_W  count of retired taken branches.

Behaviour:
- Reset (in_rst_n = 0 at a rising edge):
  - pc = RESET_PC, state = RUN, all counters = 0.
  - Reset overrides halt, go and every other input, including mid-HALT.
- States: RUN and HALT. out_halted = (state == HALT).
- Combinational decode, all arithmetic mod 2^32:
  - taken = (in_BEQ & in_equal) | (in_BNE & ~in_equal) | (in_BGEZ & ~in_rs[31]).
  - out_taken = taken & RUN.
  - br_tgt = pc + 4 + (sign-extend(in_imm16) << 2).
  - j_tgt = {pc_plus4[31:28], in_target26, 2'b00}.
  - jr_tgt = in_rs.
- Next-PC priority in RUN, without halt: in_JR → jr_tgt; else in_J or in_JW → j_tgt; else taken → br_tgt; else pc + 4.
  - in_JR wins even when in_J is also asserted.
  - Simultaneous branch flags OR into taken; there is one branch target.
- RUN with in_halt = 1:
  - pc holds; state becomes HALT next cycle.
  - Halt beats any jump or branch flag on the same cycle: the jump is not taken and not counted.
  - out_link_we = 0.
- HALT:
  - pc holds; outputs remain stable.
  - out_link_we = 0, out_taken = 0, no counter increments.
  - in_go = 1 → pc <= pc + 4 and state → RUN on the same edge.
  - in_halt is ignored while in HALT.
- out_link_we = in_JW & RUN & ~in_halt (combinational).
- Counters, updated only in RUN; each wraps to 0 after 2^CNT_W − 1:
  - cycles += 1 every RUN cycle, including the cycle in which in_halt is seen.
  - jumps += 1 when (in_J | in_JR | in_JW) & ~in_halt.
  - branches += 1 when (in_BEQ | in_BNE | in_BGEZ) & ~in_halt.
  - taken_cnt += 1 when taken & ~in_halt.
- Latency: next PC is visible on out_pc one clock after the flags are presented. Decode outputs are same-cycle combinational.

Test Plan:
- Reset then 3 idle cycles → out_pc 0x0, 0x4, 0x8, 0xC; out_cycles = 3; other counters 0.
- pc = 0x10, in_BEQ = 1, in_equal = 1, in_imm16 = 0xFFFE → next out_pc = 0x0C; out_taken = 1; branches and taken_cnt each +1.
- pc = 0x10, in_BNE = 1, in_equal = 1 → next out_pc = 0x14; branches +1, taken_cnt unchanged.
- pc = 0x3000_0000, in_JW = 1, in_target26 = 0x0000040 → out_link_we = 1, out_pc_plus4 = 0x3000_0004; next out_pc = 0x3000_0100; jumps +1.
- in_J = 1, in_JR = 1, in_rs = 0x200 → next out_pc = 0x200.
- pc = 0x20, in_halt = 1 with in_J = 1:
  - pc stays 0x20, out_halted = 1, jumps unchanged.
  - 5 cycles later cycles is unchanged.
  - in_go = 1 → out_pc = 0x24, RUN.
  - Reset asserted during HALT → out_pc = RESET_PC, RUN.
- Counter wrap with CNT_W = 4: 16 RUN cycles from reset → out_cycles returns to 0.
